ibex_cheri_cap_access_seq: RTL and testbench
============================================

// Module: ibex_cheri_cap_access_seq
// PURPOSE
//  Sequences LSU data accesses onto the 32-bit CHERI data bus. Word/half/byte accesses pass as one beat;
//  capability accesses (type 2'b11, 64b + tag) split into low/high word beats. Sits between LSU and the
//  data bus, drives the memory checker's req/type/addr view, collects its exception vector and bus errors,
//  returns one merged response per LSU request. One transaction outstanding at a time.
// PARAMETERS
//  AddrWidth     32    address width; addr+4 computed modulo 2^AddrWidth
//  ExcAbortsHi   1'b1  1: checker exception/bus error on low beat suppresses high beat
// PORTS
//  clk_i             in   1    clock
//  rst_ni            in   1    reset, asynchronous, active-low
//  lsu_req_i         in   1    LSU request; accepted when lsu_req_i & lsu_ready_o
//  lsu_ready_o       out  1    sequencer idle, can accept
//  lsu_addr_i        in   32   byte address
//  lsu_we_i          in   1    1 = store
//  lsu_type_i        in   2    00 word, 01 half, 10 byte, 11 capability
//  lsu_be_i          in   4    byte enables, non-cap accesses only
//  lsu_wdata_i       in   64   store data; [31:0] only for non-cap
//  lsu_wtag_i        in   1    store tag, cap stores only
//  lsu_resp_valid_o  out  1    one-cycle response pulse
//  lsu_rdata_o       out  64   load data ({hi,lo}; non-cap: {32'h0,word})
//  lsu_rtag_o        out  1    loaded tag
//  lsu_err_o         out  1    bus error on any issued beat
//  lsu_misaligned_o  out  1    cap access with addr[2:0]!=0 (no beat issued)
//  lsu_cheri_exc_o   out  CheriExcWidth  OR of checker exceptions over issued beats
//  data_req_o        out  1    bus request
//  data_gnt_i        in   1    bus grant
//  data_rvalid_i     in   1    bus response valid
//  data_addr_o       out  32   beat address (word-aligned for cap beats)
//  data_we_o         out  1    beat write enable
//  data_be_o         out  4    beat byte enables (4'hF for cap beats)
//  data_type_o       out  2    type seen by checker: low cap beat 11, high cap beat 00, else lsu_type
//  data_cap_o        out  1    beat is part of capability access
//  data_wdata_o      out  32   beat write data
//  data_wtag_o       out  1    beat write tag (lsu_wtag on both cap-store beats, else 0)
//  data_rdata_i      in   32   read data
//  data_rtag_i       in   1    read tag
//  data_err_i        in   1    bus error, valid with rvalid
//  cheri_exc_i       in   CheriExcWidth  checker exceptions, valid with rvalid (non-stable output mode)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except lsu_ready_o=1; request fields in registers cleared.
//  - FSM: IDLE -> REQ_LO on accept (cap misaligned: IDLE -> RESP, no bus beat). REQ_LO holds data_req_o=1,
//    addr/we/be/wdata stable until data_gnt_i -> WAIT_LO. WAIT_LO on rvalid: non-cap -> RESP; cap and
//    (err|exc!=0) and ExcAbortsHi -> RESP; else -> REQ_HI (addr+4, wdata[63:32]). REQ_HI/WAIT_HI as low.
//    WAIT_HI on rvalid -> RESP. RESP drives lsu_resp_valid_o=1 one cycle -> IDLE.
//  - data_req_o never asserted in IDLE/WAIT_*/RESP; gnt and rvalid in same cycle as req legal (WAIT_* skipped
//    only if rvalid arrives same cycle as gnt: then treat as rvalid of that beat).
//  - Request fields captured at accept; LSU inputs ignored while busy (lsu_ready_o=0 outside IDLE).
//  - Response accumulation: err/exc ORed per beat, cleared at accept; lo/hi rdata captured per beat.
//  - rtag = rtag_lo & rtag_hi for cap loads; 0 if high beat suppressed, on error, or non-cap.
//  - Suppressed high beat: rdata[63:32]=0, no second bus beat.
//  - rvalid outside WAIT_* ignored (verification assertion flags it).
//  - Async reset mid-transaction: immediate return to IDLE, data_req_o drops; no response for dropped request.
// STRUCTURE
//  - ibex_pkg: cap_seq_state_e {IDLE,REQ_LO,WAIT_LO,REQ_HI,WAIT_HI,RESP}, CheriExcWidth, type constant
//    DATA_TYPE_CAP=2'b11.
//  - Single module, no sub-modules; instantiated beside ibex_cheri_memchecker (DataMem=1, StableOut=0).
// TESTING
//  - Word load 0x1000, gnt+1, rvalid+2, rdata 0xDEADBEEF -> one beat type 00, resp rdata 0x00000000DEADBEEF, tag 0.
//  - Cap load 0x2000, beats rdata 0x11111111/0x22222222 tags 1/1 -> addrs 0x2000,0x2004, types 11/00,
//    rdata 0x2222222211111111, rtag 1; tags 1/0 -> rtag 0.
//  - Cap store 0x3008 wdata 0xAAAA_BBBB_CCCC_DDDD tag 1 -> beats wdata 0xCCCCDDDD then 0xAAAABBBB, wtag 1, cap 1, be F.
//  - Cap load low-beat cheri_exc_i LENGTH_VIOLATION set -> no high beat, exc bit set, rtag 0, rdata[63:32]=0.
//  - Cap load 0x4004 -> no data_req_o, resp next cycle with lsu_misaligned_o=1; addr 0xFFFFFFF8 -> high beat 0xFFFFFFFC.
//  - rst_ni low during REQ_HI -> data_req_o 0 same cycle, lsu_ready_o 1, no lsu_resp_valid_o after release.

Source files
------------

// File: rtl/ibex_cheri_cap_access_seq_pkg.sv
// ibex_cheri_cap_access_seq_pkg: shared types and constants for the CHERI data access sequencer.
// Contents:
//   CheriExcWidth    width of the memory checker exception vector
//   DATA_TYPE_*      LSU/checker access type encodings
//   EXC_*            individual checker exception bits
//   cap_seq_state_e  sequencer state type, with one localparam per state
package ibex_cheri_cap_access_seq_pkg;

    localparam int unsigned CheriExcWidth = 5;

    localparam logic [1:0] DATA_TYPE_WORD = 2'b00;
    localparam logic [1:0] DATA_TYPE_HALF = 2'b01;
    localparam logic [1:0] DATA_TYPE_BYTE = 2'b10;
    localparam logic [1:0] DATA_TYPE_CAP  = 2'b11;

    localparam logic [CheriExcWidth-1:0] EXC_LENGTH_VIOLATION = 5'b00001;
    localparam logic [CheriExcWidth-1:0] EXC_TAG_VIOLATION    = 5'b00010;
    localparam logic [CheriExcWidth-1:0] EXC_PERM_VIOLATION   = 5'b00100;

    typedef logic [2:0] cap_seq_state_e;

    localparam cap_seq_state_e IDLE    = 3'd0;
    localparam cap_seq_state_e REQ_LO  = 3'd1;
    localparam cap_seq_state_e WAIT_LO = 3'd2;
    localparam cap_seq_state_e REQ_HI  = 3'd3;
    localparam cap_seq_state_e WAIT_HI = 3'd4;
    localparam cap_seq_state_e RESP    = 3'd5;

endpackage

// File: rtl/ibex_cheri_cap_access_seq.sv
// ibex_cheri_cap_access_seq: splits LSU accesses into 32-bit bus beats (two for capabilities) and merges one response.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   lsu_req_i/lsu_ready_o               LSU handshake; one transaction outstanding
//   lsu_addr_i/we_i/type_i/be_i         LSU request fields, captured at accept
//   lsu_wdata_i/lsu_wtag_i              store data (64b for capabilities) and tag
//   lsu_resp_valid_o                    one-cycle merged response pulse
//   lsu_rdata_o/rtag_o/err_o            merged load data, tag and bus error
//   lsu_misaligned_o/lsu_cheri_exc_o    misaligned capability flag, ORed checker exceptions
//   data_req_o/gnt_i/rvalid_i           data bus handshake
//   data_addr_o/we_o/be_o/wdata_o/wtag_o  beat request fields
//   data_type_o/data_cap_o              access type as seen by the memory checker
//   data_rdata_i/rtag_i/err_i           beat response
//   cheri_exc_i                         checker exceptions, valid with data_rvalid_i
module ibex_cheri_cap_access_seq
    import ibex_cheri_cap_access_seq_pkg::*;
#(
    parameter int unsigned AddrWidth   = 32,
    parameter bit          ExcAbortsHi = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     lsu_req_i,
    output logic                     lsu_ready_o,
    input  logic [AddrWidth-1:0]     lsu_addr_i,
    input  logic                     lsu_we_i,
    input  logic [1:0]               lsu_type_i,
    input  logic [3:0]               lsu_be_i,
    input  logic [63:0]              lsu_wdata_i,
    input  logic                     lsu_wtag_i,
    output logic                     lsu_resp_valid_o,
    output logic [63:0]              lsu_rdata_o,
    output logic                     lsu_rtag_o,
    output logic                     lsu_err_o,
    output logic                     lsu_misaligned_o,
    output logic [CheriExcWidth-1:0] lsu_cheri_exc_o,
    output logic                     data_req_o,
    input  logic                     data_gnt_i,
    input  logic                     data_rvalid_i,
    output logic [AddrWidth-1:0]     data_addr_o,
    output logic                     data_we_o,
    output logic [3:0]               data_be_o,
    output logic [1:0]               data_type_o,
    output logic                     data_cap_o,
    output logic [31:0]              data_wdata_o,
    output logic                     data_wtag_o,
    input  logic [31:0]              data_rdata_i,
    input  logic                     data_rtag_i,
    input  logic                     data_err_i,
    input  logic [CheriExcWidth-1:0] cheri_exc_i
);

    cap_seq_state_e           state_q, state_d;
    logic [AddrWidth-1:0]     addr_q;
    logic                     we_q, wtag_q, mis_q, err_q, rtag_lo_q, rtag_hi_q;
    logic [1:0]               type_q;
    logic [3:0]               be_q;
    logic [63:0]              wdata_q;
    logic [31:0]              rdata_lo_q, rdata_hi_q;
    logic [CheriExcWidth-1:0] exc_q;

    logic cap, hi, issuing, beat_done, accept, resp, lo_next_resp;

    assign cap     = type_q == DATA_TYPE_CAP;
    assign hi      = state_q == REQ_HI || state_q == WAIT_HI;
    assign issuing = state_q == REQ_LO || state_q == REQ_HI;
    assign resp    = state_q == RESP;
    assign accept  = lsu_req_i && state_q == IDLE;
    // A response arriving in the same cycle as the grant completes the beat without visiting WAIT_*.
    assign beat_done = data_rvalid_i &&
                       ((issuing && data_gnt_i) || state_q == WAIT_LO || state_q == WAIT_HI);
    assign lo_next_resp = !cap || (ExcAbortsHi && (data_err_i || |cheri_exc_i));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lsu_req_i) state_d = (lsu_type_i == DATA_TYPE_CAP && |lsu_addr_i[2:0]) ? RESP : REQ_LO;
            REQ_LO:  if (data_gnt_i) state_d = beat_done ? (lo_next_resp ? RESP : REQ_HI) : WAIT_LO;
            WAIT_LO: if (data_rvalid_i) state_d = lo_next_resp ? RESP : REQ_HI;
            REQ_HI:  if (data_gnt_i) state_d = beat_done ? RESP : WAIT_HI;
            WAIT_HI: if (data_rvalid_i) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            type_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wtag_q     <= 1'b0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
            exc_q      <= '0;
            rdata_lo_q <= '0;
            rdata_hi_q <= '0;
            rtag_lo_q  <= 1'b0;
            rtag_hi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= lsu_addr_i;
                we_q       <= lsu_we_i;
                type_q     <= lsu_type_i;
                be_q       <= lsu_be_i;
                wdata_q    <= lsu_wdata_i;
                wtag_q     <= lsu_wtag_i;
                mis_q      <= lsu_type_i == DATA_TYPE_CAP && |lsu_addr_i[2:0];
                err_q      <= 1'b0;
                exc_q      <= '0;
                rdata_lo_q <= '0;
                rdata_hi_q <= '0;
                rtag_lo_q  <= 1'b0;
                rtag_hi_q  <= 1'b0;
            end
            if (beat_done) begin
                err_q <= err_q | data_err_i;
                exc_q <= exc_q | cheri_exc_i;
                if (hi) begin
                    rdata_hi_q <= data_rdata_i;
                    rtag_hi_q  <= data_rtag_i;
                end else begin
                    rdata_lo_q <= data_rdata_i;
                    rtag_lo_q  <= data_rtag_i;
                end
            end
        end
    end

    // A response with no beat in flight is a bus protocol violation; it is otherwise ignored.
    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (!data_rvalid_i || beat_done);
    end

    assign lsu_ready_o  = state_q == IDLE;
    assign data_req_o   = issuing;
    assign data_addr_o  = hi ? addr_q + AddrWidth'(4) : addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = cap ? 4'hF : be_q;
    assign data_type_o  = cap ? (hi ? DATA_TYPE_WORD : DATA_TYPE_CAP) : type_q;
    assign data_cap_o   = cap;
    assign data_wdata_o = hi ? wdata_q[63:32] : wdata_q[31:0];
    assign data_wtag_o  = cap && we_q && wtag_q;

    // A suppressed high beat leaves rtag_hi_q cleared, so the merged tag drops with it.
    assign lsu_resp_valid_o = resp;
    assign lsu_rdata_o      = resp ? {rdata_hi_q, rdata_lo_q} : '0;
    assign lsu_rtag_o       = resp && cap && !we_q && !err_q && rtag_lo_q && rtag_hi_q;
    assign lsu_err_o        = resp && err_q;
    assign lsu_misaligned_o = resp && mis_q;
    assign lsu_cheri_exc_o  = resp ? exc_q : '0;

endmodule

// File: tb/tb_ibex_cheri_cap_access_seq.sv
// tb_ibex_cheri_cap_access_seq: directed and randomized transactions checked against a transaction-level model.
module tb_ibex_cheri_cap_access_seq;
    import ibex_cheri_cap_access_seq_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     lsu_req_i = 1'b0;
    logic                     lsu_ready_o;
    logic [31:0]              lsu_addr_i = '0;
    logic                     lsu_we_i = 1'b0;
    logic [1:0]               lsu_type_i = '0;
    logic [3:0]               lsu_be_i = '0;
    logic [63:0]              lsu_wdata_i = '0;
    logic                     lsu_wtag_i = 1'b0;
    logic                     lsu_resp_valid_o;
    logic [63:0]              lsu_rdata_o;
    logic                     lsu_rtag_o;
    logic                     lsu_err_o;
    logic                     lsu_misaligned_o;
    logic [CheriExcWidth-1:0] lsu_cheri_exc_o;
    logic                     data_req_o;
    logic                     data_gnt_i = 1'b0;
    logic                     data_rvalid_i = 1'b0;
    logic [31:0]              data_addr_o;
    logic                     data_we_o;
    logic [3:0]               data_be_o;
    logic [1:0]               data_type_o;
    logic                     data_cap_o;
    logic [31:0]              data_wdata_o;
    logic                     data_wtag_o;
    logic [31:0]              data_rdata_i = '0;
    logic                     data_rtag_i = 1'b0;
    logic                     data_err_i = 1'b0;
    logic [CheriExcWidth-1:0] cheri_exc_i = '0;

    ibex_cheri_cap_access_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lsu_req_i(lsu_req_i), .lsu_ready_o(lsu_ready_o), .lsu_addr_i(lsu_addr_i),
        .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i), .lsu_be_i(lsu_be_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_wtag_i(lsu_wtag_i),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_rtag_o(lsu_rtag_o),
        .lsu_err_o(lsu_err_o), .lsu_misaligned_o(lsu_misaligned_o), .lsu_cheri_exc_o(lsu_cheri_exc_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_type_o(data_type_o), .data_cap_o(data_cap_o), .data_wdata_o(data_wdata_o),
        .data_wtag_o(data_wtag_o), .data_rdata_i(data_rdata_i), .data_rtag_i(data_rtag_i),
        .data_err_i(data_err_i), .cheri_exc_i(cheri_exc_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]              r_data[2];
    logic                     r_tag[2];
    logic                     r_err[2];
    logic [CheriExcWidth-1:0] r_exc[2];
    bit                       rst_at_hi = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rsp(input logic [31:0] d0, input logic t0, input logic e0, input logic [CheriExcWidth-1:0] x0,
                           input logic [31:0] d1, input logic t1, input logic e1, input logic [CheriExcWidth-1:0] x1);
        r_data[0] = d0; r_tag[0] = t0; r_err[0] = e0; r_exc[0] = x0;
        r_data[1] = d1; r_tag[1] = t1; r_err[1] = e1; r_exc[1] = x1;
    endtask

    task automatic drive_rsp(input int b);
        data_rvalid_i = 1'b1;
        data_rdata_i  = r_data[b];
        data_rtag_i   = r_tag[b];
        data_err_i    = r_err[b];
        cheri_exc_i   = r_exc[b];
    endtask

    // Runs one LSU transaction from an idle negedge and checks every bus beat and the merged response.
    task automatic run(input logic [31:0] a, input logic we, input logic [1:0] ty,
                       input logic [3:0] be, input logic [63:0] wd, input logic wt);
        bit cap, mis, same;
        int nb, issued, t;
        logic e_err;
        logic [CheriExcWidth-1:0] e_exc;
        logic [63:0] e_rd;
        logic [31:0] ea;
        cap = ty == 2'b11;
        mis = cap && a[2:0] != 3'b000;
        nb = mis ? 0 : (cap ? 2 : 1);
        issued = 0; e_err = 1'b0; e_exc = '0; e_rd = '0;
        chk("ready_idle", lsu_ready_o, 1);
        lsu_req_i = 1'b1; lsu_addr_i = a; lsu_we_i = we; lsu_type_i = ty;
        lsu_be_i = be; lsu_wdata_i = wd; lsu_wtag_i = wt;
        @(negedge clk_i);
        lsu_req_i = 1'b0; lsu_addr_i = $urandom; lsu_we_i = ~we; lsu_type_i = 2'($urandom);
        lsu_be_i = 4'($urandom); lsu_wdata_i = {$urandom, $urandom}; lsu_wtag_i = ~wt;
        chk("ready_busy", lsu_ready_o, 0);
        if (mis) chk("mis_no_req", data_req_o, 0);
        for (int b = 0; b < nb; b++) begin
            t = 0;
            while (!data_req_o && t < 10) begin
                @(negedge clk_i);
                t++;
            end
            chk("beat_req", data_req_o, 1);
            ea = (b == 1) ? a + 32'd4 : a;
            chk("beat_addr", data_addr_o, ea);
            chk("beat_type", data_type_o, cap ? (b == 1 ? 2'b00 : 2'b11) : ty);
            chk("beat_be", data_be_o, cap ? 4'hF : be);
            chk("beat_we", data_we_o, we);
            chk("beat_cap", data_cap_o, cap);
            if (we) chk("beat_wdata", data_wdata_o, (cap && b == 1) ? wd[63:32] : wd[31:0]);
            chk("beat_wtag", data_wtag_o, cap && we && wt);
            if (rst_at_hi && b == 1) begin
                rst_ni = 1'b0;
                #1;
                chk("rst_req_drop", data_req_o, 0);
                chk("rst_ready", lsu_ready_o, 1);
                @(negedge clk_i);
                rst_ni = 1'b1;
                repeat (4) begin
                    @(negedge clk_i);
                    chk("rst_no_resp", lsu_resp_valid_o, 0);
                end
                chk("rst_ready_after", lsu_ready_o, 1);
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk_i);
                chk("req_hold", data_req_o, 1);
                chk("addr_hold", data_addr_o, ea);
            end
            data_gnt_i = 1'b1;
            same = $urandom_range(0, 2) == 0;
            if (same) drive_rsp(b);
            @(negedge clk_i);
            data_gnt_i = 1'b0;
            if (!same) begin
                repeat ($urandom_range(0, 2)) begin
                    chk("no_req_wait", data_req_o, 0);
                    @(negedge clk_i);
                end
                drive_rsp(b);
                @(negedge clk_i);
            end
            data_rvalid_i = 1'b0; data_err_i = 1'b0; cheri_exc_i = '0; data_rdata_i = $urandom; data_rtag_i = 1'b0;
            if (b == 0) e_rd[31:0] = r_data[0];
            else e_rd[63:32] = r_data[1];
            e_err = e_err | r_err[b];
            e_exc = e_exc | r_exc[b];
            issued++;
            if (cap && b == 0 && (r_err[0] || r_exc[0] != '0)) break;
        end
        chk("resp_valid", lsu_resp_valid_o, 1);
        chk("resp_no_req", data_req_o, 0);
        if (!we && !mis) chk("resp_rdata", lsu_rdata_o, e_rd);
        chk("resp_rtag", lsu_rtag_o, cap && !we && issued == 2 && r_tag[0] && r_tag[1] && !e_err);
        chk("resp_err", lsu_err_o, e_err);
        chk("resp_exc", lsu_cheri_exc_o, e_exc);
        chk("resp_mis", lsu_misaligned_o, mis);
        @(negedge clk_i);
        chk("resp_pulse", lsu_resp_valid_o, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0] ty;
        #12;
        chk("rst_ready", lsu_ready_o, 1);
        chk("rst_req", data_req_o, 0);
        chk("rst_resp", lsu_resp_valid_o, 0);
        chk("rst_rdata", lsu_rdata_o, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_type", data_type_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        set_rsp(32'hDEADBEEF, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, '0);
        run(32'h1000, 1'b0, 2'b00, 4'hF, 64'h0, 1'b0);
        set_rsp(32'h11111111, 1'b1, 1'b0, '0, 32'h22222222, 1'b1, 1'b0, '0);
        run(32'h2000, 1'b0, 2'b11, 4'h0, 64'h0, 1'b0);
        set_rsp(32'h11111111, 1'b1, 1'b0, '0, 32'h22222222, 1'b0, 1'b0, '0);
        run(32'h2000, 1'b0, 2'b11, 4'h0, 64'h0, 1'b0);
        set_rsp(32'h0, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, '0);
        run(32'h3008, 1'b1, 2'b11, 4'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        set_rsp(32'h55555555, 1'b1, 1'b0, EXC_LENGTH_VIOLATION, 32'h66666666, 1'b1, 1'b0, '0);
        run(32'h2010, 1'b0, 2'b11, 4'h0, 64'h0, 1'b0);
        run(32'h4004, 1'b0, 2'b11, 4'h0, 64'h0, 1'b0);
        set_rsp(32'h12345678, 1'b1, 1'b0, '0, 32'h9ABCDEF0, 1'b1, 1'b0, '0);
        run(32'hFFFFFFF8, 1'b0, 2'b11, 4'h0, 64'h0, 1'b0);
        set_rsp(32'h0, 1'b0, 1'b1, '0, 32'h0, 1'b1, 1'b0, '0);
        run(32'h2020, 1'b0, 2'b11, 4'h0, 64'h0, 1'b0);
        set_rsp(32'hCAFEF00D, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, '0);
        run(32'h1002, 1'b1, 2'b01, 4'hC, 64'h0000_0000_5A5A_0000, 1'b1);

        for (int i = 0; i < 60; i++) begin
            ty = 2'($urandom);
            a = $urandom;
            if (ty == 2'b11 && $urandom_range(0, 4) != 0) a[2:0] = 3'b000;
            if (i % 15 == 7) begin
                ty = 2'b11;
                a = 32'hFFFFFFF8;
            end
            set_rsp($urandom, 1'($urandom), $urandom_range(0, 5) == 0,
                    ($urandom_range(0, 5) == 0) ? CheriExcWidth'($urandom_range(1, 31)) : '0,
                    $urandom, 1'($urandom), $urandom_range(0, 5) == 0,
                    ($urandom_range(0, 5) == 0) ? CheriExcWidth'($urandom_range(1, 31)) : '0);
            run(a, 1'($urandom), ty, 4'($urandom), {$urandom, $urandom}, 1'($urandom));
        end

        rst_at_hi = 1;
        set_rsp(32'h77777777, 1'b1, 1'b0, '0, 32'h88888888, 1'b1, 1'b0, '0);
        run(32'h5000, 1'b0, 2'b11, 4'h0, 64'h0, 1'b0);
        rst_at_hi = 0;
        set_rsp(32'hA5A5A5A5, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, '0);
        run(32'h6000, 1'b0, 2'b00, 4'hF, 64'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
